mult_pipe: RTL and testbench
============================

Name: mult_pipe

Overview:
- Parametrised, pipelined fixed-point multiplier for the 2ASK/QPSK modulator datapath: carrier × symbol amplitude, I/Q mixing.
- Successor to the fixed 14×14→15 multiplier core. Adds generic widths, configurable latency, valid tracking, clock-enable stall, a per-sample signed/unsigned mode, a scaling shift with saturation, and overflow flags.

Parameters:
- A_WIDTH, 14, operand a width.
- B_WIDTH, 14, operand b width.
- P_WIDTH, 15, output width.
- SHIFT, 13, right shift applied to the full product before saturation; legal range 0..A_WIDTH+B_WIDTH-1.
- LATENCY, 3, in_valid to out_valid cycles; minimum 3.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes every pipeline register, including valid bits and flags.
- in_valid  in  1  a/b/tc qualify this cycle.
- tc  in  1  1 = two's-complement operands, 0 = unsigned; travels with the sample.
- a  in  A_WIDTH  operand a.
- b  in  B_WIDTH  operand b.
- ovf_clr  in  1  clears ovf_sticky.
- out_valid  out  1  p and ovf are valid this cycle.
- p  out  P_WIDTH  scaled, saturated product.
- ovf  out  1  this sample saturated; qualified by out_valid.
- ovf_sticky  out  1  latched overflow since the last clear.

Behaviour:
- Reset: out_valid=0, p=0, ovf=0, ovf_sticky=0; all internal valid bits cleared. rst dominates ce.
- Reset mid-operation: in-flight samples are discarded. out_valid stays 0 until a new sample has traversed LATENCY enabled cycles.
- Stage 0: register a, b, tc, in_valid.
- Stage 1: full product, width A_WIDTH+B_WIDTH, signed or unsigned per tc.
- Stages 2..LATENCY-2: pure delay of product, tc and valid.
- Final stage: shift, saturate, register p/ovf/out_valid.
- With ce=1 throughout, a sample accepted at edge N appears at edge N+LATENCY.
- ce=0: nothing advances and inputs are ignored. Latency counts only cycles with ce=1.
- Full throughput: one sample per enabled cycle; no back-pressure.
- Scaling:
  - Arithmetic right shift by SHIFT when tc=1; logical when tc=0.
  - Default rounding is truncation (floor).
- Saturation:
  - tc=1: clamp to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1].
  - tc=0: clamp to [0, 2^P_WIDTH-1].
  - ovf=1 whenever a clamp occurs.
- Bubbles: final-stage valid=0 gives out_valid=0, p holds its last value, ovf=0.
- ovf_sticky:
  - Set when out_valid&ovf.
  - Cleared by ovf_clr (acts only when ce=1).
  - Set and clear in the same cycle: set wins, sticky stays 1.
- tc may change every sample; each sample uses its own tc.

Optional Feature:
- Macro MULT_PIPE_ROUND_EN.
- Defined: add 2^(SHIFT-1) to the product before the shift (round half toward +inf). The addition uses one extra guard bit so it never wraps before saturation. With SHIFT=0 nothing is added.
- Undefined: truncation only. Latency is unchanged either way.

Test Plan:
- Defaults, tc=1, a=0x1000, b=0x1000, in_valid for one cycle -> out_valid exactly 3 cycles later, p=0x0800, ovf=0.
- Defaults, tc=1, a=0x2000, b=0x2000 (-1×-1) -> p=0x2000, ovf=0. Same operands with P_WIDTH=14 -> p=0x1FFF, ovf=1, ovf_sticky=1.
- Rounding, tc=1, SHIFT=13:
  - a=1, b=0x1000: p=0 without MULT_PIPE_ROUND_EN, p=1 with it.
  - a=-1, b=0x1000: p=0x7FFF (-1) without, p=0 with.
- tc=0, P_WIDTH=14, a=b=0x3FFF -> p=0x3FFF, ovf=1.
- Back-to-back valid samples with ce toggling 1,0,1,1,0,1 -> outputs in order, each exactly 3 enabled cycles after entry; no output or flag change while ce=0.
- rst pulsed with 2 samples in flight -> out_valid stays 0 until a fresh sample completes. ovf_clr asserted in the same cycle as a new ovf -> ovf_sticky remains 1.

Source files
------------

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned fixed-point multiplier with scaling and saturation.
// Define MULT_PIPE_ROUND_EN to round half toward +inf before the scaling shift.
module mult_pipe #(
   parameter int A_WIDTH = 14,
   parameter int B_WIDTH = 14,
   parameter int P_WIDTH = 15,
   parameter int SHIFT   = 13,
   parameter int LATENCY = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic               in_valid,
   input  logic               tc,
   input  logic [A_WIDTH-1:0] a,
   input  logic [B_WIDTH-1:0] b,
   input  logic               ovf_clr,
   output logic               out_valid,
   output logic [P_WIDTH-1:0] p,
   output logic               ovf,
   output logic               ovf_sticky
);

   localparam int W  = A_WIDTH + B_WIDTH;
   localparam int D  = LATENCY - 2;
   localparam int XW = (W + 1 > P_WIDTH + 1) ? W + 1 : P_WIDTH + 1;

   localparam logic [XW-1:0] UMAX = ~({XW{1'b1}} << P_WIDTH);
   localparam logic [XW-1:0] SMAX = UMAX >> 1;
   localparam logic [XW-1:0] SMIN = ~SMAX;

   logic [A_WIDTH-1:0] a_q;
   logic [B_WIDTH-1:0] b_q;
   logic               tc0_q, v0_q;

   logic [W-1:0] pr_q  [D];
   logic         ptc_q [D];
   logic         pv_q  [D];

   logic [P_WIDTH-1:0] p_q, p_d;
   logic               ovf_q, ovf_d;
   logic               ov_q, ov_d;
   logic               sticky_q, sticky_d;

   logic [W-1:0] ax, bx, prod_d;

   // Extending to full width first makes one multiplier serve both modes
   always_comb begin
      ax = {{B_WIDTH{tc0_q & a_q[A_WIDTH-1]}}, a_q};
      bx = {{A_WIDTH{tc0_q & b_q[B_WIDTH-1]}}, b_q};
      prod_d = ax * bx;
   end

   logic [W-1:0]        fp;
   logic                ftc, fv;
   logic [W:0]          ext, rnd, lsh, sh;
   logic signed [W:0]   ash;
   logic [XW-1:0]       xs;
   logic [P_WIDTH-1:0]  sat;
   logic                clamp;

   assign fp  = pr_q[D-1];
   assign ftc = ptc_q[D-1];
   assign fv  = pv_q[D-1];
   assign ext = {ftc & fp[W-1], fp};

`ifdef MULT_PIPE_ROUND_EN
   localparam int         RS  = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [W:0] RND = (SHIFT > 0) ? ((W + 1)'(1) << RS) : '0;
   assign rnd = ext + RND;
`else
   assign rnd = ext;
`endif

   assign ash = $signed(rnd) >>> SHIFT;
   assign lsh = rnd >> SHIFT;
   assign sh  = ftc ? ash : lsh;

   always_comb begin
      clamp = 1'b0;
      sat   = sh[P_WIDTH-1:0];
      if (ftc) begin
         xs = XW'($signed(sh));
         if ($signed(xs) > $signed(SMAX)) begin
            clamp = 1'b1;
            sat   = SMAX[P_WIDTH-1:0];
         end else if ($signed(xs) < $signed(SMIN)) begin
            clamp = 1'b1;
            sat   = SMIN[P_WIDTH-1:0];
         end else begin
            sat   = xs[P_WIDTH-1:0];
         end
      end else begin
         xs = XW'(sh);
         if (xs > UMAX) begin
            clamp = 1'b1;
            sat   = UMAX[P_WIDTH-1:0];
         end else begin
            sat   = xs[P_WIDTH-1:0];
         end
      end
   end

   // A bubble keeps p but drops the per-sample flag
   always_comb begin
      p_d   = p_q;
      ovf_d = 1'b0;
      ov_d  = fv;
      if (fv) begin
         p_d   = sat;
         ovf_d = clamp;
      end
      sticky_d = (sticky_q & ~ovf_clr) | (ov_q & ovf_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         tc0_q    <= 1'b0;
         v0_q     <= 1'b0;
         for (int i = 0; i < D; i++) begin
            pr_q[i]  <= '0;
            ptc_q[i] <= 1'b0;
            pv_q[i]  <= 1'b0;
         end
         p_q      <= '0;
         ovf_q    <= 1'b0;
         ov_q     <= 1'b0;
         sticky_q <= 1'b0;
      end else if (ce) begin
         a_q      <= a;
         b_q      <= b;
         tc0_q    <= tc;
         v0_q     <= in_valid;
         pr_q[0]  <= prod_d;
         ptc_q[0] <= tc0_q;
         pv_q[0]  <= v0_q;
         for (int i = 1; i < D; i++) begin
            pr_q[i]  <= pr_q[i-1];
            ptc_q[i] <= ptc_q[i-1];
            pv_q[i]  <= pv_q[i-1];
         end
         p_q      <= p_d;
         ovf_q    <= ovf_d;
         ov_q     <= ov_d;
         sticky_q <= sticky_d;
      end
   end

   assign out_valid  = ov_q;
   assign p          = p_q;
   assign ovf        = ovf_q;
   // Visible in the same cycle as the overflowing sample
   assign ovf_sticky = sticky_q | (ov_q & ovf_q);

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: default instance plus a P_WIDTH=14 instance.
// Expected values are hand-computed for SHIFT=13.
module tb_mult_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b1;
   logic        in_valid = 1'b0;
   logic        tc = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [13:0] a = '0;
   logic [13:0] b = '0;

   logic        ov, ovf, st;
   logic [14:0] p;
   logic        ov14, ovf14, st14;
   logic [13:0] p14;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef MULT_PIPE_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   always #5 clk = ~clk;

   mult_pipe u_d (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .tc(tc),
      .a(a), .b(b), .ovf_clr(ovf_clr), .out_valid(ov), .p(p),
      .ovf(ovf), .ovf_sticky(st)
   );

   mult_pipe #(.P_WIDTH(14)) u_p14 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .tc(tc),
      .a(a), .b(b), .ovf_clr(ovf_clr), .out_valid(ov14), .p(p14),
      .ovf(ovf14), .ovf_sticky(st14)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_one(input logic t, input logic [13:0] va,
                          input logic [13:0] vb);
      @(negedge clk);
      ce = 1'b1; in_valid = 1'b1; tc = t; a = va; b = vb;
      @(negedge clk);
      in_valid = 1'b0;
      chk("lat_c1", 32'(ov), 32'd0);
      @(negedge clk);
      chk("lat_c2", 32'(ov), 32'd0);
      @(negedge clk);
      chk("lat_c3", 32'(ov), 32'd1);
      chk("lat14_c3", 32'(ov14), 32'd1);
   endtask

   typedef struct {
      int          idx;
      logic [14:0] p;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   bit          mon_en = 1'b0;
   int          ecnt = 0;
   int          n_out = 0;
   logic        m_ce, m_v, m_st;
   logic [14:0] m_p;

   always @(posedge clk) begin
      if (mon_en) begin
         m_ce = ce; m_v = ov; m_p = p; m_st = st;
         if (ce && in_valid)
            exp_q.push_back('{ecnt, 15'(a >> 1)});
         #1;
         if (!m_ce) begin
            chk("hold_v", 32'(ov), 32'(m_v));
            chk("hold_p", 32'(p), 32'(m_p));
            chk("hold_st", 32'(st), 32'(m_st));
         end else begin
            ecnt++;
            if (ov) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  chk("ce_extra", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("ce_p", 32'(p), 32'(e.p));
                  chk("ce_lat", 32'(ecnt - e.idx), 32'd3);
               end
            end
         end
      end
   end

   initial begin
      logic [5:0] pat;
      pat = 6'b101101;

      repeat (3) @(negedge clk);
      chk("rst_v", 32'(ov), 32'd0);
      chk("rst_p", 32'(p), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_st", 32'(st), 32'd0);
      chk("rst_v14", 32'(ov14), 32'd0);
      chk("rst_st14", 32'(st14), 32'd0);
      rst = 1'b0;

      run_one(1'b1, 14'h1000, 14'h1000);
      chk("half_p", 32'(p), 32'h0800);
      chk("half_ovf", 32'(ovf), 32'd0);
      chk("half_p14", 32'(p14), 32'h0800);
      @(negedge clk);
      chk("bub_v", 32'(ov), 32'd0);
      chk("bub_p", 32'(p), 32'h0800);

      run_one(1'b1, 14'h2000, 14'h2000);
      chk("m1m1_p", 32'(p), 32'h2000);
      chk("m1m1_ovf", 32'(ovf), 32'd0);
      chk("m1m1_st", 32'(st), 32'd0);
      chk("m1m1_p14", 32'(p14), 32'h1FFF);
      chk("m1m1_ovf14", 32'(ovf14), 32'd1);
      chk("m1m1_st14", 32'(st14), 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("clr_set_st14", 32'(st14), 32'd1);
      chk("bub_ovf14", 32'(ovf14), 32'd0);
      chk("bub_p14", 32'(p14), 32'h1FFF);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("clr_st14", 32'(st14), 32'd0);

      run_one(1'b1, 14'h0001, 14'h1000);
      chk("rnd_pos_p", 32'(p), RND ? 32'd1 : 32'd0);
      chk("rnd_pos_p14", 32'(p14), RND ? 32'd1 : 32'd0);

      run_one(1'b1, 14'h3FFF, 14'h1000);
      chk("rnd_neg_p", 32'(p), RND ? 32'd0 : 32'h7FFF);
      chk("rnd_neg_p14", 32'(p14), RND ? 32'd0 : 32'h3FFF);
      chk("rnd_neg_ovf", 32'(ovf), 32'd0);

      run_one(1'b0, 14'h3FFF, 14'h3FFF);
      chk("uns_p", 32'(p), 32'h7FFC);
      chk("uns_ovf", 32'(ovf), 32'd0);
      chk("uns_p14", 32'(p14), 32'h3FFF);
      chk("uns_ovf14", 32'(ovf14), 32'd1);
      chk("uns_st14", 32'(st14), 32'd1);
      @(negedge clk);
      chk("uns_bub_ovf14", 32'(ovf14), 32'd0);
      chk("uns_bub_p14", 32'(p14), 32'h3FFF);

      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         mon_en = 1'b1;
         ce = pat[k]; in_valid = 1'b1; tc = 1'b1;
         a = 14'(2 * (k + 1)); b = 14'h1000;
      end
      @(negedge clk);
      in_valid = 1'b0; ce = 1'b1;
      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      chk("ce_nout", 32'(n_out), 32'd4);
      chk("ce_left", 32'(exp_q.size()), 32'd0);

      @(negedge clk);
      in_valid = 1'b1; tc = 1'b1; a = 14'd2; b = 14'h1000;
      @(negedge clk);
      a = 14'd4;
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_v0", 32'(ov), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mid_rst_v", 32'(ov), 32'd0);
      end
      run_one(1'b1, 14'd6, 14'h1000);
      chk("fresh_p", 32'(p), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
